// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU
// Signed ops divide magnitudes and fix the signs afterwards; zero divisor and overflow bypass the loop.
module seq_divider #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  state_t           state;
  logic             op_rem;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CNT_W-1:0] cnt;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             is_zero;
  logic             is_ovf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // op[0] set means unsigned: operands are never treated as negative
  assign sa      = dividend[WIDTH-1] & ~op[0];
  assign sb      = divisor[WIDTH-1] & ~op[0];
  assign abs_a   = sa ? -dividend : dividend;
  assign abs_b   = sb ? -divisor : divisor;
  assign is_zero = (divisor == '0);
  assign is_ovf  = ~op[0] && (dividend == MIN_NEG) && (divisor == '1);

  // Partial remainder is always below the divisor, so WIDTH+1 bits hold the trial and its borrow
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_q};
  assign borrow  = trial[WIDTH];

  assign q_fix = q_neg ? -quo_q : quo_q;
  assign r_fix = r_neg ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      op_rem      <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      cnt         <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_rem   <= op[1];
            q_neg    <= sa ^ sb;
            r_neg    <= sa;
            rem_q    <= '0;
            quo_q    <= abs_a;
            dsr_q    <= abs_b;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (is_zero) begin
              result      <= op[1] ? dividend : '1;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else if (is_ovf) begin
              result      <= op[1] ? '0 : dividend;
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          quo_q <= {quo_q[WIDTH-2:0], ~borrow};
          rem_q <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          result      <= op_rem ? r_fix : q_fix;
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
